synaptic_current_gen: RTL and testbench
=======================================

Name: synaptic_current_gen

Overview:
- Upstream feeder for the Izhikevich neuron: converts presynaptic spike events into a Q16.16 synaptic current that drives the neuron's current input.
- Models an exponentially decaying synapse: each accepted spike adds a signed weight, and the total decays geometrically on a divided tick.
- A constant bias is added and the result saturated.
- A refractory state machine stops level-held spikes, or spikes that arrive too close together, from being counted twice.

Parameters:
- TAU_SHIFT, 4, decay shift; each decay tick does I_syn -= I_syn >>> TAU_SHIFT (1..15).
- DECAY_DIV, 16, clock cycles per decay tick (>=1).
- REFRACT_CYCLES, 8, cycles during which new rising edges are ignored after an accepted event (>=1).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = operate; 0 = freeze all state except the pre_spike_d sampler.
- pre_spike  in  1  presynaptic spike level; may be held high for several cycles.
- weight  in  32  signed Q16.16 increment per accepted event.
- bias  in  32  signed Q16.16 constant current added to the output.
- current  out  32  signed Q16.16 registered output, equal to sat(i_syn + bias); connects to the neuron current input.
- i_syn  out  32  signed Q16.16 synaptic state register.
- event_pulse  out  1  registered; high for one cycle after an accepted event.
- refractory  out  1  high while the FSM is in REFRACT.
- spike_count  out  16  accepted-event count, saturating at 16'hFFFF.

Behaviour:
- Reset (async, active-high):
  - i_syn=0, current=0, event_pulse=0, spike_count=0, refractory=0.
  - FSM=READY, tick counter=0, pre_spike_d=0, refract counter=0.
  - Deasserting reset mid-operation restarts from these values, with no residual current.
- Edge detect:
  - pre_spike_d <= pre_spike every cycle, regardless of enable.
  - rise = pre_spike & ~pre_spike_d.
- Event:
  - evt = enable & rise & (FSM==READY).
  - A rise in REFRACT, or while enable=0, is dropped. It is not queued.
- Tick counter:
  - Increments when enable=1.
  - tick = enable & (cnt==DECAY_DIV-1); on tick, cnt wraps to 0.
  - DECAY_DIV=1 gives a tick every enabled cycle.
- Decay term:
  - dec = i_syn >>> TAU_SHIFT (arithmetic shift).
  - If dec==0 and i_syn!=0, use dec = sign(i_syn) × 1 LSB, so i_syn always reaches exactly 0.
- i_syn update per cycle (in order, within one cycle):
  - t = tick ? i_syn - dec : i_syn.
  - t2 = evt ? t + weight : t.
  - Compute in 34-bit signed, then saturate to [-2^31, 2^31-1] and store.
  - Simultaneous tick and event: decay first, then add the weight.
- Output path:
  - current <= sat32(i_syn + bias), using the i_syn value before this edge's update.
  - So current lags i_syn by one cycle. Latency from the sampled rising edge to current is 2 posedges.
  - current updates even when enable=0 (it tracks the frozen i_syn and a possibly changing bias).
- FSM:
  - READY --evt--> REFRACT: load refract counter = REFRACT_CYCLES-1, set refractory=1 on the same edge.
  - REFRACT: counter decrements when enable=1. At 0 with enable=1, go to READY.
  - Total REFRACT dwell = REFRACT_CYCLES enabled cycles.
  - A rise arriving on the exact cycle READY is re-entered is accepted.
- event_pulse <= evt.
- spike_count <= spike_count+1 on evt unless already 16'hFFFF, which holds.
- Weight sign: negative weight gives inhibitory current; the same saturation rules apply.
- Widths: all datapath values signed 32-bit Q16.16. Intermediate sums 34-bit. No truncation apart from the shift.

Test Plan:
- Reset then idle 100 cycles, weight=655360 (10.0), bias=0 -> current=0, i_syn=0, spike_count=0, event_pulse never high.
- Defaults, single 1-cycle pre_spike pulse, weight=655360 -> i_syn=655360 one edge after sampling; current=655360 one edge later; after the next decay tick i_syn=614400; event_pulse high 1 cycle; spike_count=1.
- pre_spike held high 50 cycles, then 2 pulses spaced 4 cycles apart (REFRACT_CYCLES=8) -> only the first edge of the held level is accepted; the second pulse is rejected (refractory=1); spike_count=2 overall if the third edge is spaced >=8 cycles.
- weight=32'sh7FFF0000 with 3 events spaced 10 cycles, bias=32'sh10000000 -> i_syn saturates at 32'sh7FFFFFFF, current=32'sh7FFFFFFF, no wrap to negative; repeat with negative weights -> clamps at 32'sh80000000.
- i_syn=3 (one event with weight=3), bias=0, run 1000 cycles -> i_syn decrements 1 LSB per tick to exactly 0 and stays there; same for weight=-3.
- Assert reset while i_syn=655360 and FSM in REFRACT -> all outputs 0 immediately (asynchronously); a pulse 2 cycles after release is accepted.

Source files
------------

// File: rtl/synaptic_current_gen.sv
// Exponentially decaying synapse: accepted presynaptic edges add a signed Q16.16 weight,
// the state decays geometrically on a divided tick, and a biased, saturated current is registered.
module synaptic_current_gen #(
  parameter int unsigned TAU_SHIFT      = 4,
  parameter int unsigned DECAY_DIV      = 16,
  parameter int unsigned REFRACT_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               pre_spike,
  input  logic signed [31:0] weight,
  input  logic signed [31:0] bias,
  output logic signed [31:0] current,
  output logic signed [31:0] i_syn,
  output logic               event_pulse,
  output logic               refractory,
  output logic [15:0]        spike_count
);

  if (TAU_SHIFT < 1 || TAU_SHIFT > 15) begin : g_bad_tau
    $error("TAU_SHIFT must be in 1..15");
  end
  if (DECAY_DIV < 1) begin : g_bad_div
    $error("DECAY_DIV must be >= 1");
  end
  if (REFRACT_CYCLES < 1) begin : g_bad_refract
    $error("REFRACT_CYCLES must be >= 1");
  end

  localparam int unsigned CntW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int unsigned RefW = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(DECAY_DIV - 1);
  localparam logic [RefW-1:0] RefLoad = RefW'(REFRACT_CYCLES - 1);
  localparam logic signed [33:0] SatMax = 34'sd2147483647;
  localparam logic signed [33:0] SatMin = -34'sd2147483648;

  typedef enum logic [0:0] {StReady, StRefract} state_e;

  state_e             state_q, state_d;
  logic [RefW-1:0]    ref_cnt_q, ref_cnt_d;
  logic [CntW-1:0]    tick_cnt_q, tick_cnt_d;
  logic               pre_spike_q;
  logic signed [31:0] i_syn_q, i_syn_d;
  logic signed [31:0] current_q, current_d;
  logic               event_pulse_q;
  logic [15:0]        spike_count_q, spike_count_d;

  logic               rise;
  logic               evt;
  logic               tick;
  logic signed [31:0] dec_raw;
  logic signed [31:0] dec;
  logic signed [33:0] isyn_ext;
  logic signed [33:0] sum;

  function automatic logic signed [31:0] sat32(input logic signed [33:0] v);
    logic signed [31:0] r;
    if (v > SatMax) begin
      r = 32'sh7FFF_FFFF;
    end else if (v < SatMin) begin
      r = 32'sh8000_0000;
    end else begin
      r = v[31:0];
    end
    return r;
  endfunction

  assign rise = pre_spike & ~pre_spike_q;
  assign evt  = enable & rise & (state_q == StReady);
  assign tick = enable & (tick_cnt_q == CntMax);

  assign isyn_ext = {{2{i_syn_q[31]}}, i_syn_q};
  assign dec_raw  = i_syn_q >>> TAU_SHIFT;

  // Small positive values shift to zero; force a 1 LSB step so decay always lands on exactly 0.
  always_comb begin
    dec = dec_raw;
    if (dec_raw == 32'sd0 && i_syn_q != 32'sd0) begin
      dec = i_syn_q[31] ? -32'sd1 : 32'sd1;
    end
  end

  // Decay is applied before the weight when both happen on the same cycle.
  always_comb begin
    sum = isyn_ext;
    if (tick) begin
      sum = sum - {{2{dec[31]}}, dec};
    end
    if (evt) begin
      sum = sum + {{2{weight[31]}}, weight};
    end
    i_syn_d   = sat32(sum);
    current_d = sat32(isyn_ext + {{2{bias[31]}}, bias});
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (enable) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + CntW'(1);
    end
  end

  always_comb begin
    spike_count_d = spike_count_q;
    if (evt && spike_count_q != 16'hFFFF) begin
      spike_count_d = spike_count_q + 16'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ref_cnt_d = ref_cnt_q;
    case (state_q)
      StReady: begin
        if (evt) begin
          state_d   = StRefract;
          ref_cnt_d = RefLoad;
        end
      end
      StRefract: begin
        if (enable) begin
          if (ref_cnt_q == '0) begin
            state_d = StReady;
          end else begin
            ref_cnt_d = ref_cnt_q - RefW'(1);
          end
        end
      end
      default: state_d = StReady;
    endcase
  end

  // The edge sampler runs regardless of enable so a level held across enable stays one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_spike_q <= 1'b0;
    end else begin
      pre_spike_q <= pre_spike;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StReady;
      ref_cnt_q     <= '0;
      tick_cnt_q    <= '0;
      i_syn_q       <= '0;
      current_q     <= '0;
      event_pulse_q <= 1'b0;
      spike_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ref_cnt_q     <= ref_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      i_syn_q       <= i_syn_d;
      current_q     <= current_d;
      event_pulse_q <= evt;
      spike_count_q <= spike_count_d;
    end
  end

  assign current     = current_q;
  assign i_syn       = i_syn_q;
  assign event_pulse = event_pulse_q;
  assign refractory  = (state_q == StRefract);
  assign spike_count = spike_count_q;

endmodule

// File: tb/tb_synaptic_current_gen.sv
// Bench for synaptic_current_gen: an arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_synaptic_current_gen;

  localparam int TauShift      = 4;
  localparam int DecayDiv      = 16;
  localparam int RefractCycles = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic               pre_spike = 1'b0;
  logic signed [31:0] weight = '0;
  logic signed [31:0] bias = '0;
  logic signed [31:0] current;
  logic signed [31:0] i_syn;
  logic               event_pulse;
  logic               refractory;
  logic [15:0]        spike_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  synaptic_current_gen #(
    .TAU_SHIFT      (TauShift),
    .DECAY_DIV      (DecayDiv),
    .REFRACT_CYCLES (RefractCycles)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pre_spike   (pre_spike),
    .weight      (weight),
    .bias        (bias),
    .current     (current),
    .i_syn       (i_syn),
    .event_pulse (event_pulse),
    .refractory  (refractory),
    .spike_count (spike_count)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: synaptic state as a plain integer, refractory as remaining enabled cycles.
  longint m_isyn;
  longint m_cur;
  bit     m_pulse;
  bit     m_prev;
  int     m_count;
  int     m_ref_left;
  int     m_phase;
  logic   m_accept;

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint decay_of(input longint v);
    longint div;
    longint d;
    div = longint'(1) << TauShift;
    if (v >= 0) d = v / div;
    else d = -((-v + div - 1) / div);
    if (d == 0 && v != 0) d = (v > 0) ? 64'sd1 : -64'sd1;
    return d;
  endfunction

  function automatic longint next_isyn(input longint v, input bit is_tick, input bit acc,
                                       input longint w);
    longint n;
    n = v;
    if (is_tick) n = n - decay_of(n);
    if (acc) n = n + w;
    return clamp32(n);
  endfunction

  assign m_accept = enable && pre_spike && !m_prev && (m_ref_left == 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_isyn     <= 0;
      m_cur      <= 0;
      m_pulse    <= 1'b0;
      m_prev     <= 1'b0;
      m_count    <= 0;
      m_ref_left <= 0;
      m_phase    <= 0;
    end else begin
      m_cur <= clamp32(m_isyn + longint'(bias));
      if (enable) begin
        m_isyn  <= next_isyn(m_isyn, m_phase == DecayDiv - 1, m_accept, longint'(weight));
        m_phase <= (m_phase + 1) % DecayDiv;
        if (m_accept) begin
          m_ref_left <= RefractCycles;
          if (m_count < 65535) m_count <= m_count + 1;
        end else if (m_ref_left > 0) begin
          m_ref_left <= m_ref_left - 1;
        end
      end
      m_pulse <= m_accept;
      m_prev  <= pre_spike;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("model_current", current, m_cur);
      check("model_i_syn", i_syn, m_isyn);
      check("model_event_pulse", event_pulse, m_pulse);
      check("model_refractory", refractory, m_ref_left > 0);
      check("model_spike_count", spike_count, m_count);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    pre_spike = 1'b1;
    cyc(1);
    pre_spike = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    int k;
    #1;
    do_reset();

    // Idle after reset: nothing moves.
    enable = 1'b1;
    weight = 32'sd655360;
    bias   = 32'sd0;
    cyc(100);
    check("idle_current", current, 0);
    check("idle_i_syn", i_syn, 0);
    check("idle_count", spike_count, 0);

    // Single pulse, then the first decay tick.
    pulse();
    check("single_i_syn", i_syn, 655360);
    check("single_pulse", event_pulse, 1);
    check("single_current_lag", current, 0);
    check("single_count", spike_count, 1);
    cyc(1);
    check("single_current", current, 655360);
    check("single_pulse_off", event_pulse, 0);
    k = 0;
    while (i_syn == 32'sd655360 && k < 40) begin
      cyc(1);
      k++;
    end
    check("single_decay", i_syn, 614400);

    // A rise while disabled is dropped; current still follows bias.
    cyc(10);
    enable = 1'b0;
    bias   = 32'sd100;
    pulse();
    cyc(2);
    check("disabled_count", spike_count, 1);
    check("disabled_pulse", event_pulse, 0);
    enable = 1'b1;
    bias   = 32'sd0;
    cyc(3);

    // Held level counts once; a pulse inside the refractory window is dropped.
    do_reset();
    weight    = 32'sd65536;
    pre_spike = 1'b1;
    cyc(50);
    check("held_count", spike_count, 1);
    pre_spike = 1'b0;
    cyc(10);
    pulse();
    check("pulse_a_count", spike_count, 2);
    check("pulse_a_refr", refractory, 1);
    cyc(3);
    check("pulse_b_refr", refractory, 1);
    pulse();
    check("pulse_b_count", spike_count, 2);
    cyc(10);
    pulse();
    check("pulse_c_count", spike_count, 3);

    // Positive saturation.
    do_reset();
    bias   = 32'sh1000_0000;
    weight = 32'sh7FFF_0000;
    pulse();
    check("satp_first", i_syn, 64'sh7FFF_0000);
    cyc(9);
    pulse();
    cyc(9);
    pulse();
    check("satp_i_syn", i_syn, 64'sd2147483647);
    cyc(1);
    check("satp_current", current, 64'sd2147483647);

    // Negative saturation.
    do_reset();
    bias   = 32'shF000_0000;
    weight = 32'sh8001_0000;
    pulse();
    cyc(9);
    pulse();
    cyc(9);
    pulse();
    check("satn_i_syn", i_syn, -64'sd2147483648);
    cyc(1);
    check("satn_current", current, -64'sd2147483648);

    // Small values decay to exactly zero.
    do_reset();
    bias   = 32'sd0;
    weight = 32'sd3;
    pulse();
    check("small_pos_start", i_syn, 3);
    cyc(1000);
    check("small_pos_end", i_syn, 0);
    check("small_pos_current", current, 0);
    do_reset();
    weight = -32'sd3;
    pulse();
    check("small_neg_start", i_syn, -3);
    cyc(1000);
    check("small_neg_end", i_syn, 0);
    check("small_neg_current", current, 0);

    // Asynchronous reset mid-refractory, then a fresh event.
    do_reset();
    weight = 32'sd655360;
    pulse();
    cyc(2);
    check("arst_pre_refr", refractory, 1);
    check("arst_pre_i_syn", i_syn, 655360);
    check("arst_pre_current", current, 655360);
    #2;
    reset = 1'b1;
    #1;
    check("arst_current", current, 0);
    check("arst_i_syn", i_syn, 0);
    check("arst_pulse", event_pulse, 0);
    check("arst_refr", refractory, 0);
    check("arst_count", spike_count, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(2);
    pulse();
    check("post_arst_count", spike_count, 1);
    check("post_arst_i_syn", i_syn, 655360);
    check("post_arst_pulse", event_pulse, 1);
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
